// File: rtl/order_queue_display.sv
// order_queue_display
//   Holds up to N_ORDERS live kitchen orders. Each order has a dish type and a
//   countdown timer in seconds. Timers age on a once-per-second tick, and
//   timeouts are reported to game logic. One card is drawn per slot: the dish
//   sprite, with a countdown bar under it. The bar shrinks as time runs out
//   and flashes red when time is low.
//
// Ports
//   pixel_clk_in     pixel clock (sole clock)
//   rst_n_in         asynchronous active-low reset
//   hcount_in        current pixel x
//   vcount_in        current pixel y
//   sec_tick_in      one-cycle pulse, once per second
//   new_valid_in     new order request
//   new_ready_out    high while at least one slot is free
//   new_dish_in      dish index of the new order
//   new_time_in      starting seconds of the new order (0 is loaded as 1)
//   serve_valid_in   order served pulse
//   serve_slot_in    index of the slot being served
//   active_out       per-slot occupied flags
//   expire_mask_out  one-cycle pulse per slot that timed out
//   sprite_addr_out  {dish, row, col} address to the sprite ROM
//   sprite_pix_in    sprite ROM data for the registered address
//   pixel_out        rendered colour, 0 outside cards (2-cycle latency)
module order_queue_display #(
  parameter int          N_ORDERS    = 4,
  parameter int          DISH_W      = 2,
  parameter int          TIME_W      = 5,
  parameter int          SPRITE_W    = 32,
  parameter logic [9:0]  X0          = 10'd8,
  parameter logic [8:0]  Y0          = 9'd8,
  parameter int          GAP         = 8,
  parameter int          BAR_H       = 4,
  parameter int          LOW_TIME    = 5,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  localparam int         LOG_S       = $clog2(SPRITE_W),
  localparam int         ADDR_W      = DISH_W + 2 * LOG_S
) (
  input  logic                pixel_clk_in,
  input  logic                rst_n_in,
  input  logic [9:0]          hcount_in,
  input  logic [8:0]          vcount_in,
  input  logic                sec_tick_in,
  input  logic                new_valid_in,
  output logic                new_ready_out,
  input  logic [DISH_W-1:0]   new_dish_in,
  input  logic [TIME_W-1:0]   new_time_in,
  input  logic                serve_valid_in,
  input  logic [2:0]          serve_slot_in,
  output logic [N_ORDERS-1:0] active_out,
  output logic [N_ORDERS-1:0] expire_mask_out,
  output logic [ADDR_W-1:0]   sprite_addr_out,
  input  logic [11:0]         sprite_pix_in,
  output logic [11:0]         pixel_out
);

  localparam int SLOT_W = (N_ORDERS > 1) ? $clog2(N_ORDERS) : 1;

  localparam logic [TIME_W-1:0] ONE_T   = TIME_W'(1);
  localparam logic [TIME_W-1:0] LOW_T   = TIME_W'(LOW_TIME);
  localparam logic [10:0]       SPR11   = 11'(SPRITE_W);
  localparam logic [10:0]       Y_TOP   = 11'(Y0);
  localparam logic [10:0]       BAR_TOP = 11'(Y0) + 11'(SPRITE_W) + 11'd2;
  localparam logic [10:0]       BAR_H11 = 11'(BAR_H);

  typedef enum logic [1:0] {
    HIT_NONE,
    HIT_SPRITE,
    HIT_BAR
  } hit_t;

  // Slot state
  logic [N_ORDERS-1:0] active_q, active_d;
  logic [N_ORDERS-1:0] expire_q, expire_d;
  logic [TIME_W-1:0]   timer_q [N_ORDERS];
  logic [TIME_W-1:0]   timer_d [N_ORDERS];
  logic [DISH_W-1:0]   dish_q  [N_ORDERS];
  logic [DISH_W-1:0]   dish_d  [N_ORDERS];
  logic                flash_q, flash_d;
  logic [N_ORDERS-1:0] serve_hit;
  logic                alloc_done;

  // Render pipeline
  hit_t              hit_type_q, hit_type_d;
  logic [SLOT_W-1:0] hit_slot_q, hit_slot_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       pix_q, pix_d;
  logic [10:0]       hx, vy, card_x, bar_w;

  // Bar length in pixels: timer scaled onto the card width.
  // Any live timer is shown at least 1 px wide, so it never vanishes early.
  function automatic logic [10:0] bar_width(input logic [TIME_W-1:0] t);
    int w;
    w = (32'(t) * SPRITE_W) >> TIME_W;
    if ((t != '0) && (w == 0)) w = 1;
    return 11'(w);
  endfunction

  assign new_ready_out   = |(~active_q);
  assign active_out      = active_q;
  assign expire_mask_out = expire_q;
  assign sprite_addr_out = addr_q;
  assign pixel_out       = pix_q;

  assign hx = {1'b0, hcount_in};
  assign vy = {2'b0, vcount_in};

  always_comb begin
    serve_hit = '0;
    for (int i = 0; i < N_ORDERS; i++) begin
      serve_hit[i] = serve_valid_in && ({1'b0, serve_slot_in} == 4'(i)) && active_q[i];
    end
  end

  // Every decision looks only at active_q, so a slot freed this cycle
  // (by serve or by expiry) is not reused until the next cycle.
  // A serve takes priority over a tick expiry, so a served slot never
  // raises an expire pulse.
  always_comb begin
    active_d   = active_q;
    timer_d    = timer_q;
    dish_d     = dish_q;
    expire_d   = '0;
    flash_d    = flash_q ^ sec_tick_in;
    alloc_done = 1'b0;
    for (int i = 0; i < N_ORDERS; i++) begin
      if (active_q[i]) begin
        if (serve_hit[i]) begin
          active_d[i] = 1'b0;
          timer_d[i]  = '0;
        end else if (sec_tick_in) begin
          if (timer_q[i] > ONE_T) begin
            timer_d[i] = timer_q[i] - ONE_T;
          end else begin
            active_d[i] = 1'b0;
            timer_d[i]  = '0;
            expire_d[i] = 1'b1;
          end
        end
      end else if (new_valid_in && !alloc_done) begin
        alloc_done  = 1'b1;
        active_d[i] = 1'b1;
        dish_d[i]   = new_dish_in;
        timer_d[i]  = (new_time_in == '0) ? ONE_T : new_time_in;
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      active_q <= '0;
      expire_q <= '0;
      flash_q  <= 1'b0;
      for (int i = 0; i < N_ORDERS; i++) begin
        timer_q[i] <= '0;
        dish_q[i]  <= '0;
      end
    end else begin
      active_q <= active_d;
      expire_q <= expire_d;
      flash_q  <= flash_d;
      timer_q  <= timer_d;
      dish_q   <= dish_d;
    end
  end

  // Stage 1: find which card (if any) the beam is over, and form the ROM
  // address. Cards never overlap, so the first match is the only match.
  always_comb begin
    hit_type_d = HIT_NONE;
    hit_slot_d = '0;
    addr_d     = '0;
    card_x     = '0;
    bar_w      = '0;
    for (int i = 0; i < N_ORDERS; i++) begin
      card_x = 11'(X0) + 11'(i * (SPRITE_W + GAP));
      bar_w  = bar_width(timer_q[i]);
      if (hit_type_d == HIT_NONE) begin
        if ((hx >= card_x) && (hx < card_x + SPR11) &&
            (vy >= Y_TOP) && (vy < Y_TOP + SPR11)) begin
          hit_type_d = HIT_SPRITE;
          hit_slot_d = SLOT_W'(i);
          addr_d     = {dish_q[i], LOG_S'(vy - Y_TOP), LOG_S'(hx - card_x)};
        end else if ((hx >= card_x) && (hx < card_x + bar_w) &&
                     (vy >= BAR_TOP) && (vy < BAR_TOP + BAR_H11)) begin
          hit_type_d = HIT_BAR;
          hit_slot_d = SLOT_W'(i);
        end
      end
    end
  end

  // Stage 2: colour the pixel. Slot state is read live here, so an order
  // served or expired mid-frame disappears from the next pixel onward.
  always_comb begin
    pix_d = '0;
    for (int i = 0; i < N_ORDERS; i++) begin
      if ((hit_slot_q == SLOT_W'(i)) && active_q[i]) begin
        if (hit_type_q == HIT_SPRITE) begin
          pix_d = (sprite_pix_in == TRANSPARENT) ? 12'h000 : sprite_pix_in;
        end else if (hit_type_q == HIT_BAR) begin
          if (timer_q[i] > LOW_T) pix_d = 12'h0F0;
          else                    pix_d = flash_q ? 12'hF00 : 12'h400;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hit_type_q <= HIT_NONE;
      hit_slot_q <= '0;
      addr_q     <= '0;
      pix_q      <= '0;
    end else begin
      hit_type_q <= hit_type_d;
      hit_slot_q <= hit_slot_d;
      addr_q     <= addr_d;
      pix_q      <= pix_d;
    end
  end

endmodule
